// File: rtl/mem_access_unit.sv
// mem_access_unit: arbitrates a fetch port and a data port onto one handshaked memory bus.
// Define MAU_TIMEOUT_EN to abort accesses whose handshake does not arrive within TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 err,
  output logic [WORD_SIZE-1:0] access_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t               r_state;
  logic                 r_port_d;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_cnt;
  logic                 r_read;
  logic                 r_write;
  logic                 r_if_ready;
  logic                 r_d_ready;

  logic w_busy;
  logic w_hs;
  logic w_abort;
  logic w_done_entry;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be nonzero");
  end

  assign w_busy       = (r_state == S_RD) || (r_state == S_WR);
  assign w_hs         = ((r_state == S_RD) && inputReady) || ((r_state == S_WR) && ackOutput);
  assign w_done_entry = w_hs || w_abort;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_tmo_cnt;
  logic            r_err;

  // A handshake in the final allowed cycle still wins over the abort.
  assign w_abort = w_busy && !w_hs && (r_tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err     = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_busy) r_tmo_cnt <= r_tmo_cnt + TO_W'(1);
      else        r_tmo_cnt <= '0;
      if (w_done_entry)          r_err <= w_abort;
      else if (r_state == S_DONE) r_err <= 1'b0;
    end
  end
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  // Main access FSM; strobes and ready pulses are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_port_d   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (d_req) begin
            r_port_d <= 1'b1;
            r_addr   <= d_addr;
            r_wdata  <= d_wdata;
            if (d_we) begin
              r_state <= S_WR;
              r_write <= 1'b1;
            end else begin
              r_state <= S_RD;
              r_read  <= 1'b1;
            end
          end else if (if_req) begin
            r_port_d <= 1'b0;
            r_addr   <= if_addr;
            r_state  <= S_RD;
            r_read   <= 1'b1;
          end
        end
        S_RD, S_WR: begin
          if (w_done_entry) begin
            r_state    <= S_DONE;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_if_ready <= !r_port_d;
            r_d_ready  <= r_port_d;
            r_cnt      <= r_cnt + WORD_SIZE'(1);
            if (w_abort)               r_rdata <= '0;
            else if (r_state == S_RD)  r_rdata <= data;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_if_ready <= 1'b0;
          r_d_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = r_write ? r_wdata : {WORD_SIZE{1'bz}};
  assign readM      = r_read;
  assign writeM     = r_write;
  assign address    = r_addr;
  assign rdata      = r_rdata;
  assign if_ready   = r_if_ready;
  assign d_ready    = r_d_ready;
  assign access_cnt = r_cnt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected completions, a monitor checks ready pulses.
// Timeout scenario is built only when MAU_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic [15:0] rdata;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady;
  logic        ackOutput;
  logic        err;
  logic [15:0] access_cnt;

  logic        mem_drv;
  logic [15:0] mem_val;

  typedef struct packed {
    logic        is_d;
    logic [15:0] rdata;
    logic        chk_rdata;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests;
  int          n_fail;
  logic [15:0] exp_cnt;
  logic [15:0] last_rd;

  assign data = mem_drv ? mem_val : {16{1'bz}};
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pu (data[g]);
  end

  mem_access_unit #(.WORD_SIZE(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .rdata(rdata), .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .ackOutput(ackOutput), .err(err), .access_cnt(access_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && (if_ready || d_ready)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 32'({if_ready, d_ready}), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ready_port", 32'({if_ready, d_ready}), e.is_d ? 32'd1 : 32'd2);
        if (e.chk_rdata) chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("err", 32'(err), 32'(e.err));
        chk("access_cnt", 32'(access_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic [15:0] rv, input logic chk_rd, input logic e_err);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.is_d = is_d; e.rdata = rv; e.chk_rdata = chk_rd; e.err = e_err; e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_strobes"}, 32'({readM, writeM}), 32'd0);
    chk({tag, "_data_hiz"}, 32'(data), 32'h0000ffff);
  endtask

  // One complete access: handshake arrives after 'waits' extra strobe cycles.
  task automatic do_access(input logic is_d, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rval, input int waits);
    push_exp(is_d, rval, !we, 1'b0);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      chk(we ? "writeM" : "readM", 32'(we ? writeM : readM), 32'd1);
      chk("address", 32'(address), 32'(addr));
      if (we) chk("data_drive", 32'(data), 32'(wdata));
      if (i == waits) begin
        if (we) ackOutput = 1'b1;
        else begin inputReady = 1'b1; mem_drv = 1'b1; mem_val = rval; end
      end
      @(posedge clk); #1;
    end
    chk("ready_timing", 32'(is_d ? d_ready : if_ready), 32'd1);
    inputReady = 1'b0; ackOutput = 1'b0; mem_drv = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if (!we) last_rd = rval;
    #1 idle_checks("done");
    @(posedge clk); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = 16'd0; last_rd = 16'd0;
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; inputReady = 1'b0; ackOutput = 1'b0;
    mem_drv = 1'b0; mem_val = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'({if_ready, d_ready, err}), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_cnt", 32'(access_cnt), 32'd0);
    idle_checks("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 0);
    do_access(1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 3);
    do_access(1'b1, 1'b0, 16'h0024, 16'h0000, 16'hC0DE, 2);
    chk("rdata_after_read", 32'(rdata), 32'hC0DE);

    // Simultaneous requests: data port first, then the fetch.
    push_exp(1'b1, 16'hAAAA, 1'b1, 1'b0);
    push_exp(1'b0, 16'h5555, 1'b1, 1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030; if_req = 1'b1; if_addr = 16'h0034;
    @(posedge clk); #1;
    chk("prio_addr_d", 32'(address), 32'h0030);
    chk("prio_readM_d", 32'(readM), 32'd1);
    inputReady = 1'b1; mem_drv = 1'b1; mem_val = 16'hAAAA;
    @(posedge clk); #1;
    chk("prio_if_ready_low", 32'(if_ready), 32'd0);
    inputReady = 1'b0; mem_drv = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("prio_addr_if", 32'(address), 32'h0034);
    chk("prio_readM_if", 32'(readM), 32'd1);
    inputReady = 1'b1; mem_drv = 1'b1; mem_val = 16'h5555;
    @(posedge clk); #1;
    inputReady = 1'b0; mem_drv = 1'b0; if_req = 1'b0;
    last_rd = 16'h5555;
    repeat (2) @(posedge clk);
    #1;

    // Spurious handshakes while idle must change nothing.
    inputReady = 1'b1; ackOutput = 1'b1; mem_drv = 1'b1; mem_val = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_strobes", 32'({readM, writeM}), 32'd0);
    inputReady = 1'b0; ackOutput = 1'b0; mem_drv = 1'b0;
    chk("spur_cnt", 32'(access_cnt), 32'(exp_cnt));
    chk("spur_rdata", 32'(rdata), 32'(last_rd));

    // Reset mid-read drops the access silently.
    if_req = 1'b1; if_addr = 16'h0040;
    @(posedge clk); #1;
    chk("rst_mid_readM_before", 32'(readM), 32'd1);
    reset_n = 1'b0; if_req = 1'b0;
    #1;
    chk("rst_mid_readM", 32'(readM), 32'd0);
    chk("rst_mid_addr", 32'(address), 32'd0);
    chk("rst_mid_cnt", 32'(access_cnt), 32'd0);
    exp_cnt = 16'd0; last_rd = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h5A5A, 1);

`ifdef MAU_TIMEOUT_EN
    push_exp(1'b0, 16'h0000, 1'b1, 1'b1);
    if_req = 1'b1; if_addr = 16'h0060;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_readM", 32'(readM), 32'd1);
      @(posedge clk); #1;
    end
    chk("tmo_ready", 32'(if_ready), 32'd1);
    if_req = 1'b0;
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the data and address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the handshake wait limit; it is used only with MAU_TIMEOUT_EN.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 if_req  input  1  SHALL be the fetch-port read request, level, held until if_ready.
REQ-006 if_addr  input  WORD_SIZE  SHALL be the fetch address.
REQ-007 if_ready  output  1  SHALL be the one-cycle fetch completion pulse.
REQ-008 d_req, d_we  input  1 each  SHALL be the data-port request (level, held until d_ready) and the write select.
REQ-009 d_addr, d_wdata  input  WORD_SIZE each  SHALL be the data address and write data.
REQ-010 d_ready  output  1  SHALL be the one-cycle data completion pulse.
REQ-011 rdata  output  WORD_SIZE  SHALL be the read result, valid while if_ready or d_ready is high.
REQ-012 readM, writeM  output  1 each  SHALL be the memory read and write strobes.
REQ-013 address  output  WORD_SIZE  SHALL be the registered memory address.
REQ-014 data  inout  WORD_SIZE  SHALL be the shared memory data bus.
REQ-015 inputReady, ackOutput  input  1 each  SHALL be the memory read-done and write-done handshakes.
REQ-016 err  output  1  SHALL flag an aborted access, valid with the ready pulse.
REQ-017 access_cnt  output  WORD_SIZE  SHALL give the count of completed accesses.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR and DONE; DONE SHALL always return to IDLE on the next cycle.
REQ-019 In IDLE, d_req SHALL win over if_req.
- Grant: latch address/write data/port ID, then go to RD (read) or WR (d_we=1).
REQ-020 Strobes: readM=1 exactly while in RD; writeM=1 exactly while in WR; address stable for the whole access.
REQ-021 data SHALL be driven with the latched write data only in WR, and high-Z in all other states.
REQ-022 RD exit: on a rising edge with inputReady=1, latch data into rdata and go to DONE.
REQ-023 WR exit: on a rising edge with ackOutput=1, go to DONE.
REQ-024 In DONE, the granted port's ready SHALL be 1 for one cycle; the other ready SHALL stay 0.
REQ-025 access_cnt SHALL increment on entry to DONE and wrap from 2^WORD_SIZE-1 to 0.
REQ-026 Minimum latency SHALL be: request at cycle 0 -> strobe at cycle 1 -> handshake sampled at end of cycle 1 -> ready at cycle 2.
REQ-027 Requests and handshakes arriving outside their states SHALL be ignored; a spurious inputReady or ackOutput has no effect.
REQ-028 Fetch starvation under continuous d_req is permitted (fixed priority).

Reset
REQ-029 While reset_n=0:
- state = IDLE.
- readM, writeM, if_ready, d_ready, err = 0.
- address, rdata, access_cnt = 0.
- data = high-Z.
REQ-030 An access in flight when reset asserts SHALL be dropped without a ready pulse.

Configuration
REQ-031 With MAU_TIMEOUT_EN defined, a counter SHALL clear on RD/WR entry and count cycles in RD/WR.
- On reaching TIMEOUT_CYCLES with no handshake: go to DONE with err=1 and rdata=0; access_cnt still increments.
REQ-032 Without MAU_TIMEOUT_EN, RD/WR SHALL wait indefinitely, err SHALL be tied 0, and no counter is built.

Verification
REQ-033 if_req=1, if_addr=0x0010, inputReady pulsed in cycle 1 with data=0x1234 -> if_ready in cycle 2, rdata=0x1234, access_cnt=1.
REQ-034 d_req=1, d_we=1, d_addr=0x0020, d_wdata=0xBEEF, ackOutput after 3 cycles -> writeM high for 4 cycles, data=0xBEEF meanwhile, then d_ready pulse, data high-Z.
REQ-035 if_req and d_req both raised in the same cycle -> data access completes first, then the fetch; two ready pulses in that order.
REQ-036 reset_n dropped while in RD -> readM=0 immediately, no if_ready; after release, a new request completes normally.
REQ-037 MAU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no inputReady -> after 4 RD cycles, if_ready=1, err=1, rdata=0.
